reg_file_wr_demux: RTL and testbench
====================================

REG_FILE_WR_DEMUX -- requirements
Module: reg_file_wr_demux

Interface
REQ-001 Parameter DATA_W, default 32, register and bus width in bits.
REQ-002 Parameter ADDR_W, default 5, register-select width; depth is 2**ADDR_W (32 entries).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 regWrite  input  1  write enable for the current cycle.
REQ-006 writeReg  input  ADDR_W  destination register index; the 1-to-32 demux select.
REQ-007 writeData  input  DATA_W  data bus steered to the selected register.
REQ-008 readReg1  input  ADDR_W  read port 1 index.
REQ-009 readReg2  input  ADDR_W  read port 2 index.
REQ-010 readData1  output  DATA_W  read port 1 data, combinational.
REQ-011 readData2  output  DATA_W  read port 2 data, combinational.
REQ-012 wrValid  output  1  registered; high for one cycle after a committed write.
REQ-013 wrRegLast  output  ADDR_W  registered index of the last committed write.

Function
REQ-014 Write decode SHALL be a one-hot 1-to-2**ADDR_W demux of writeReg, gated by regWrite; at most one storage register loads per cycle.
REQ-015 On a rising clk edge with regWrite=1 and writeReg!=0, entry[writeReg] SHALL load writeData; all other entries SHALL hold.
REQ-016 Entry 0 SHALL be hardwired to zero; a write to index 0 SHALL be discarded, and SHALL NOT count as committed.
REQ-017 With regWrite=0, no entry SHALL change, regardless of writeReg or writeData.
REQ-018 readDataN SHALL equal entry[readRegN], with zero latency (combinational).
REQ-019 Write-through bypass: if regWrite=1, writeReg!=0 and readRegN==writeReg in the same cycle, readDataN SHALL equal writeData, not the stored value.
REQ-020 Bypass SHALL apply to both read ports independently and simultaneously, including readReg1==readReg2==writeReg.
REQ-021 A read of index 0 SHALL return 0 even when regWrite=1 and writeReg=0.
REQ-022 wrValid SHALL be 1 in the cycle following a committed write (REQ-015), else 0.
REQ-023 wrRegLast SHALL update to writeReg only on a committed write; otherwise it SHALL hold its value.
REQ-024 Back-to-back writes to the same index SHALL commit in order; the later write wins.
REQ-025 Width rule: data SHALL pass unmodified; no sign or zero extension inside the block.

Reset
REQ-026 While reset=1, all entries SHALL asynchronously clear to 0, independent of clk.
REQ-027 While reset=1, wrValid SHALL be 0 and wrRegLast SHALL be 0.
REQ-028 While reset=1, writes SHALL be blocked and bypass disabled, so readDataN=0 for every index.
REQ-029 Reset asserted mid-write (same cycle as a clk edge with regWrite=1) SHALL win; the entry SHALL remain 0.
REQ-030 The first write SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-031 Reset, then readReg1=0..31 sweep -> readData1=0x00000000 for all indices; wrValid=0 and wrRegLast=0.
REQ-032 Write 0xDEADBEEF to r5, then read r5 and r6 -> readData1=0xDEADBEEF, readData2=0; next cycle wrValid=1, wrRegLast=5.
REQ-033 Write 0x12345678 to r0, read r0 same and next cycle -> readData=0 both cycles; wrValid stays 0; wrRegLast unchanged.
REQ-034 r9 holds 0x1; same cycle write 0xA5A5A5A5 to r9 with readReg1=readReg2=9 -> both readData=0xA5A5A5A5 pre-edge and post-edge.
REQ-035 Write 0xFFFFFFFF to each of r1..r31 with distinct readback -> each index returns its own value, no aliasing; then regWrite=0 with writeReg=3 and new data -> r3 unchanged.
REQ-036 Assert reset asynchronously between clk edges after REQ-035 -> all reads 0 immediately, with no clk edge needed; deassert and write r7=0x55 -> r7=0x55 after one edge.

Source files
------------

// File: rtl/reg_file_wr_demux.sv
// Register file whose write path is an explicit one-hot 1-to-2**ADDR_W demux.
// Entry 0 reads as zero. Both read ports bypass a same-cycle committed write.
`timescale 1ns/1ps
module reg_file_wr_demux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              wrValid,
    output logic [ADDR_W-1:0] wrRegLast
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_entry [1:DEPTH-1];
    logic [DATA_W-1:0] w_entry [DEPTH];
    logic [DEPTH-1:1]  w_wr_sel;
    logic              w_commit;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_reg_last;

    // A write commits only outside reset and never to the hardwired zero entry.
    assign w_commit = regWrite & ~reset & (writeReg != '0);

    // One-hot write decode; the select for index 0 simply does not exist.
    always_comb begin
        w_wr_sel = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            w_wr_sel[i] = w_commit & (writeReg == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_entry[i] <= writeData;
                end
            end
        end
    end

    // Flat read view with entry 0 tied off.
    always_comb begin
        w_entry[0] = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            w_entry[i] = r_entry[i];
        end
    end

    // Write-through bypass; w_commit already excludes reset and index 0.
    always_comb begin
        readData1 = w_entry[readReg1];
        readData2 = w_entry[readReg2];
        if (w_commit && (readReg1 == writeReg)) begin
            readData1 = writeData;
        end
        if (w_commit && (readReg2 == writeReg)) begin
            readData2 = writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_valid    <= 1'b0;
            r_wr_reg_last <= '0;
        end else begin
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_reg_last <= writeReg;
            end
        end
    end

    assign wrValid   = r_wr_valid;
    assign wrRegLast = r_wr_reg_last;

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Self-checking bench for reg_file_wr_demux: directed table, corner sequences,
// and randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_file_wr_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        wrValid;
    logic [4:0]  wrRegLast;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_reg [32];
    logic        m_valid;
    logic [4:0]  m_last;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_valid;
        logic [4:0]  exp_last;
    } vec_t;

    vec_t vecs [10];

    reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .wrValid   (wrValid),
        .wrRegLast (wrRegLast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        regWrite  = we;
        writeReg  = wa;
        writeData = wd;
        readReg1  = ra1;
        readReg2  = ra2;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_valid = 1'b0;
        m_last  = '0;
    endtask

    // Reference read: zero in reset or for index 0, else newest value incl. this cycle's write.
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (reset || idx == 5'd0) return 32'h0;
        if (regWrite && writeReg == idx) return writeData;
        return m_reg[idx];
    endfunction

    // Clock edge with model update; returns 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (regWrite && writeReg != 5'd0) begin
            m_reg[writeReg] = writeData;
            m_valid = 1'b1;
            m_last  = writeReg;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        apply(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Reset held: sweep every index with a competing write; nothing may leak through.
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
            #0.2;
            check($sformatf("rst_sweep_rd1[%0d]", i), readData1, 32'h0);
        end
        check("rst_wrValid", {31'h0, wrValid}, 32'h0);
        check("rst_wrRegLast", {27'h0, wrRegLast}, 32'h0);

        // Write pending with reset high across an edge must be lost.
        apply(1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4);
        tick();
        reset = 1'b0;
        apply(1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
        #2;
        check("rst_edge_r4", readData1, 32'h0);
        check("rst_edge_wrValid", {31'h0, wrValid}, 32'h0);
        check("rst_edge_wrRegLast", {27'h0, wrRegLast}, 32'h0);

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        1'b1, 5'd5};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        1'b0, 5'd5};
        vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd5};
        vecs[3] = '{1'b0, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd5};
        vecs[4] = '{1'b1, 5'd9, 32'h1,        5'd9, 5'd9, 32'h1,        32'h1,        1'b1, 5'd9};
        vecs[5] = '{1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 5'd9};
        vecs[6] = '{1'b0, 5'd9, 32'h0,        5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 5'd9};
        vecs[7] = '{1'b1, 5'd9, 32'h11,       5'd9, 5'd5, 32'h11,       32'hDEADBEEF, 1'b1, 5'd9};
        vecs[8] = '{1'b1, 5'd9, 32'h22,       5'd9, 5'd5, 32'h22,       32'hDEADBEEF, 1'b1, 5'd9};
        vecs[9] = '{1'b0, 5'd3, 32'hFFFF,     5'd9, 5'd3, 32'h22,       32'h0,        1'b0, 5'd9};

        // First row also proves a write right after reset release is accepted.
        for (int v = 0; v < 10; v++) begin
            apply(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
            #3;
            check($sformatf("vec%0d_rd1", v), readData1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), readData2, vecs[v].exp2);
            tick();
            check($sformatf("vec%0d_wrValid", v), {31'h0, wrValid}, {31'h0, vecs[v].exp_valid});
            check($sformatf("vec%0d_wrRegLast", v), {27'h0, wrRegLast}, {27'h0, vecs[v].exp_last});
        end

        // Randomized traffic with bias toward bypass hits and index 0.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            logic [4:0] ra1;
            logic [4:0] ra2;
            wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            apply(1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2);
            #3;
            check("rnd_rd1", readData1, model_read(readReg1));
            check("rnd_rd2", readData2, model_read(readReg2));
            tick();
            check("rnd_wrValid", {31'h0, wrValid}, {31'h0, m_valid});
            check("rnd_wrRegLast", {27'h0, wrRegLast}, {27'h0, m_last});
        end

        // Fill every entry with a distinct all-ones-based value and read all back.
        for (int i = 1; i < 32; i++) begin
            apply(1'b1, 5'(i), 32'hFFFFFFFF, 5'd0, 5'd0);
            tick();
            apply(1'b1, 5'(i), 32'hFFFF_FF00 | 32'(i), 5'd0, 5'd0);
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            apply(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
            #0.2;
            check($sformatf("fill_rd1[%0d]", i), readData1, 32'hFFFF_FF00 | 32'(i));
            check($sformatf("fill_rd2[%0d]", 32 - i), readData2, 32'hFFFF_FF00 | 32'(32 - i));
        end
        tick();
        apply(1'b0, 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd3);
        tick();
        #2;
        check("nowrite_r3", readData1, 32'hFFFF_FF03);
        check("nowrite_wrValid", {31'h0, wrValid}, 32'h0);

        // Leave wrValid high, then assert reset between edges.
        apply(1'b1, 5'd10, 32'h1010_1010, 5'd10, 5'd10);
        tick();
        apply(1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        #1;
        check("pre_async_wrValid", {31'h0, wrValid}, 32'h1);
        reset = 1'b1;
        model_clear();
        #0.1;
        check("async_wrValid", {31'h0, wrValid}, 32'h0);
        check("async_wrRegLast", {27'h0, wrRegLast}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(31 - i);
            #0.1;
            check($sformatf("async_rd1[%0d]", i), readData1, 32'h0);
            check($sformatf("async_rd2[%0d]", 31 - i), readData2, 32'h0);
        end
        reset = 1'b0;
        apply(1'b1, 5'd7, 32'h55, 5'd1, 5'd2);
        tick();
        apply(1'b0, 5'd0, 32'h0, 5'd7, 5'd10);
        #2;
        check("post_rst_r7", readData1, 32'h55);
        check("post_rst_r10", readData2, 32'h0);
        check("post_rst_wrValid", {31'h0, wrValid}, 32'h1);
        check("post_rst_wrRegLast", {27'h0, wrRegLast}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
